// File: rtl/serial_frame_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_deser_pkg
// Brief    : Shared state type and default framing constants for the deserializer.
// Revision : 1.0 - initial release
// ============================================================================
package frame_deser_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } deser_state_t;

    localparam int          DEF_WIDTH     = 8;
    localparam int          DEF_NWORDS    = 2;
    localparam logic [7:0]  DEF_SYNC_WORD = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/serial_frame_deser_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_deser_if
// Brief    : Serial input and parallel word/status outputs of the deserializer.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_frame_deser_if #(
    parameter int WIDTH = 8
);
    logic             din;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             locked;
    logic             sync_err;

    modport master (
        output din,
        input  data_out,
        input  data_valid,
        input  locked,
        input  sync_err
    );

    modport slave (
        input  din,
        output data_out,
        output data_valid,
        output locked,
        output sync_err
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_deser_sipo_shift.sv
`default_nettype none
// ============================================================================
// Module   : sipo_shift
// Brief    : Serial-in/parallel-out register, MSB-first, synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_shift #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             clr,
    input  wire logic             en,
    input  wire logic             sin,
    output logic      [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = {q_q[WIDTH-2:0], sin};
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;
endmodule
`default_nettype wire

// File: rtl/serial_frame_deser.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_deser
// Brief    : Sync-word hunting serial-to-parallel frame deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_deser
    import frame_deser_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               NWORDS    = DEF_NWORDS,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEF_SYNC_WORD)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    serial_frame_deser_if.slave   bus
);
    localparam int BCW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int GCW = $clog2(WIDTH + 1);

    localparam logic [BCW-1:0] c_bit_last   = BCW'(WIDTH - 1);
    localparam logic [WCW-1:0] c_word_last  = WCW'(NWORDS - 1);
    localparam logic [GCW-1:0] c_guard_full = GCW'(WIDTH);
    localparam logic [GCW-1:0] c_guard_min  = GCW'(WIDTH - 1);

    deser_state_t     state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [GCW-1:0]   guard_q, guard_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             locked_q, locked_d;
    logic             sync_err_q, sync_err_d;

    logic [WIDTH-1:0] w_win;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_win_next;
    logic [WIDTH-1:0] w_word_next;
    logic             w_win_clr;
    logic             w_unused;

    sipo_shift #(.WIDTH(WIDTH)) u_win (
        .clk (clk),
        .clr (reset | w_win_clr),
        .en  (state_q == HUNT),
        .sin (bus.din),
        .q   (w_win)
    );

    // Word register also collects the post-frame sync word in CHECK.
    sipo_shift #(.WIDTH(WIDTH)) u_word (
        .clk (clk),
        .clr (reset),
        .en  (state_q != HUNT),
        .sin (bus.din),
        .q   (w_word)
    );

    // Decisions use the register contents plus the bit sampled at this edge.
    assign w_win_next  = {w_win[WIDTH-2:0], bus.din};
    assign w_word_next = {w_word[WIDTH-2:0], bus.din};
    assign w_unused    = ^{w_win[WIDTH-1], w_word[WIDTH-1]};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        guard_d      = guard_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        locked_d     = locked_q;
        sync_err_d   = 1'b0;
        w_win_clr    = 1'b0;

        case (state_q)
            HUNT: begin
                if (guard_q != c_guard_full) begin
                    guard_d = guard_q + GCW'(1);
                end
                if ((w_win_next == SYNC_WORD) && (guard_q >= c_guard_min)) begin
                    state_d    = DATA;
                    locked_d   = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_cnt_q == c_bit_last) begin
                    bit_cnt_d    = '0;
                    data_out_d   = w_word_next;
                    data_valid_d = 1'b1;
                    if (word_cnt_q == c_word_last) begin
                        word_cnt_d = '0;
                        state_d    = CHECK;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            CHECK: begin
                if (bit_cnt_q == c_bit_last) begin
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    if (w_word_next == SYNC_WORD) begin
                        state_d = DATA;
                    end else begin
                        state_d    = HUNT;
                        locked_d   = 1'b0;
                        sync_err_d = 1'b1;
                        guard_d    = '0;
                        w_win_clr  = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            default: begin
                state_d  = HUNT;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            guard_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            guard_q      <= guard_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            locked_q     <= locked_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.locked     = locked_q;
    assign bus.sync_err   = sync_err_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_frame_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_deser
// Brief    : Directed bench: default-sync instance plus a 8'h05 guard instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_deser;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic din = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Activity seen on all bits of a burst except the last one.
    int early_valid_a;
    int early_err_a;
    int early_lock_a;
    int early_lock_b;

    serial_frame_deser_if #(.WIDTH(8)) bus_a ();
    serial_frame_deser_if #(.WIDTH(8)) bus_b ();

    assign bus_a.din = din;
    assign bus_b.din = din;

    serial_frame_deser #(.WIDTH(8), .NWORDS(2), .SYNC_WORD(8'hA5)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    serial_frame_deser #(.WIDTH(8), .NWORDS(2), .SYNC_WORD(8'h05)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        early_valid_a = 0;
        early_err_a   = 0;
        early_lock_a  = 0;
        early_lock_b  = 0;
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i]);
            if (i != 0) begin
                early_valid_a += int'(bus_a.data_valid);
                early_err_a   += int'(bus_a.sync_err);
                early_lock_a  += int'(bus_a.locked);
                early_lock_b  += int'(bus_b.locked);
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(i[0]);
        reset = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [7:0] w);
        send_bits(32'(w), 8);
        check_val({tag, "_valid"}, 32'(bus_a.data_valid), 32'd1);
        check_val({tag, "_data"}, 32'(bus_a.data_out), 32'(w));
        check_val({tag, "_gap"}, early_valid_a, 0);
    endtask

    initial begin
        // Reset held 5 cycles with din toggling.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_bit(i[0]);
            check_val("rst_data_out", 32'(bus_a.data_out), 32'd0);
            check_val("rst_valid", 32'(bus_a.data_valid), 32'd0);
            check_val("rst_locked", 32'(bus_a.locked), 32'd0);
            check_val("rst_sync_err", 32'(bus_a.sync_err), 32'd0);
        end
        reset = 1'b0;

        // Normal frame, second sync, second frame.
        send_bits(32'hA5, 8);
        check_val("nrm_early_lock", early_lock_a, 0);
        check_val("nrm_lock", 32'(bus_a.locked), 32'd1);
        check_val("nrm_lock_valid", 32'(bus_a.data_valid), 32'd0);
        expect_word("nrm_w0", 8'h3C);
        expect_word("nrm_w1", 8'hC3);
        send_bits(32'hA5, 8);
        check_val("nrm_sync2_valid", early_valid_a + int'(bus_a.data_valid), 0);
        check_val("nrm_sync2_locked", 32'(bus_a.locked), 32'd1);
        check_val("nrm_sync2_err", early_err_a + int'(bus_a.sync_err), 0);
        expect_word("nrm_w2", 8'h11);
        expect_word("nrm_w3", 8'h22);
        check_val("nrm_err", 32'(bus_a.sync_err), 32'd0);
        send_bit(1'b1);
        check_val("nrm_hold", 32'(bus_a.data_out), 32'h22);
        check_val("nrm_pulse", 32'(bus_a.data_valid), 32'd0);

        // Bad resync then relock.
        apply_reset();
        send_bits(32'hA5, 8);
        expect_word("bad_w0", 8'h3C);
        expect_word("bad_w1", 8'hC3);
        send_bits(32'hFF, 8);
        check_val("bad_early_err", early_err_a, 0);
        check_val("bad_err", 32'(bus_a.sync_err), 32'd1);
        check_val("bad_unlock", 32'(bus_a.locked), 32'd0);
        send_bit(1'b1);
        check_val("bad_err_pulse", 32'(bus_a.sync_err), 32'd0);
        send_bits(32'h25, 7);
        check_val("bad_relock_early", early_lock_a, 0);
        check_val("bad_relock", 32'(bus_a.locked), 32'd1);

        // Offset hunt: noise before the sync word.
        apply_reset();
        send_bits(32'h5, 3);
        check_val("off_noise", 32'(bus_a.locked), 32'd0);
        send_bits(32'hA5, 8);
        check_val("off_early_lock", early_lock_a, 0);
        check_val("off_lock", 32'(bus_a.locked), 32'd1);
        expect_word("off_w0", 8'h7E);
        expect_word("off_w1", 8'h81);

        // Guard instance: leading-zero sync word must not match zero-fill.
        apply_reset();
        send_bits(32'h5, 3);
        check_val("grd_early", early_lock_b + int'(bus_b.locked), 0);
        send_bits(32'h05, 8);
        check_val("grd_early_lock", early_lock_b, 0);
        check_val("grd_lock", 32'(bus_b.locked), 32'd1);

        // Reset asserted at data bit 4.
        apply_reset();
        send_bits(32'hA5, 8);
        expect_word("mid_w0", 8'h3C);
        send_bits(32'hC, 4);
        check_val("mid_pre_locked", 32'(bus_a.locked), 32'd1);
        reset = 1'b1;
        send_bit(1'b0);
        reset = 1'b0;
        check_val("mid_data_out", 32'(bus_a.data_out), 32'd0);
        check_val("mid_locked", 32'(bus_a.locked), 32'd0);
        check_val("mid_valid", 32'(bus_a.data_valid), 32'd0);
        check_val("mid_err", 32'(bus_a.sync_err), 32'd0);
        send_bits(32'h3A5, 11);
        check_val("mid_no_valid", early_valid_a + int'(bus_a.data_valid), 0);
        check_val("mid_early_lock", early_lock_a, 0);
        check_val("mid_relock", 32'(bus_a.locked), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/serial_frame_deser.md
# serial_frame_deser

Serial-to-parallel frame deserializer that sits directly downstream of `good_shift_reg` and consumes its 1-bit `dout` stream, one bit per clock. It hunts for a sync word, then packs the following bits MSB-first into `NWORDS` data words per frame, pulsing `data_valid` for each word. After every frame it checks for the next sync word. On a mismatch it flags an error and returns to hunting.

## Interface
- `WIDTH`, 8: bits per data word and per sync word.
- `NWORDS`, 2: data words per frame, between sync words; must be ≥ 1.
- `SYNC_WORD`, 8'hA5: sync pattern, `WIDTH` bits, transmitted MSB-first.

Ports:
- `clk`  input  1  — single clock; all state updates on its rising edge.
- `reset`  input  1  — synchronous, active-high.
- `din`  input  1  — serial data; one new bit sampled every clock, first bit is MSB.
- `data_out`  output  WIDTH  — last completed data word; held until the next word completes.
- `data_valid`  output  1  — one-cycle pulse; `data_out` is new.
- `locked`  output  1  — high while in DATA or CHECK.
- `sync_err`  output  1  — one-cycle pulse when the post-frame sync check fails.

## Operation
- Reset, at the clock edge with `reset`=1:
  - state ← HUNT;
  - `data_out` = 0; `data_valid` = 0; `locked` = 0; `sync_err` = 0;
  - hunt window, bit counter, word counter and guard counter all = 0.
  - Reset wins over every other event. This includes reset asserted mid-word: no `data_valid` is produced for a partial word.
- **HUNT**
  - Each edge shifts `din` into the LSB of a `WIDTH`-bit window.
  - A guard counter saturates at `WIDTH`.
  - Match condition: {window[WIDTH-2:0], din} == `SYNC_WORD` and the guard shows ≥ `WIDTH`-1 bits already collected. The guard stops zero-fill after reset from creating false matches for sync words with leading zeros.
  - On a match: → DATA; `locked` ← 1; bit counter = 0; word counter = 0.
- **DATA**
  - Bits shift into the word register.
  - At the edge sampling bit `WIDTH`-1:
    - `data_out` ← completed word;
    - `data_valid` ← 1;
    - the word counter increments.
  - If this was word `NWORDS`-1: → CHECK.
- **CHECK**
  - Collect `WIDTH` bits.
  - At the edge sampling the last bit, compare with `SYNC_WORD`:
    - match → DATA (`locked` stays 1, counters cleared);
    - mismatch → HUNT, with `locked` ← 0, `sync_err` ← 1 for one cycle, window and guard cleared.
- Bit order: the first received bit of each word lands in `data_out[WIDTH-1]`.
- The block has no backpressure. Output consumers must take each word during its `data_valid` cycle.
- Counter widths: bit counter `$clog2(WIDTH)`, word counter `$clog2(NWORDS)` (minimum 1 bit). Counters wrap to 0 at the terminal count, never past it.

## Timing
- Every bit clock carries data; there are no idle cycles.
- `data_valid`, `locked` and `sync_err` are registered. They change at the same edge that samples the deciding bit, so the latency is 0 cycles after the last bit's sampling edge.
- With `WIDTH`=8, successive `data_valid` pulses are exactly 8 cycles apart inside a frame. Between the last word of one frame and the first word of the next, the gap is 16 cycles (one sync word plus one data word).
- After a lock or a check match, the first data bit is the one sampled at the very next edge.
- `data_out` changes only on `data_valid` edges and on reset.

## Structure
- Shared package `frame_deser_pkg` holds:
  - the state typedef `deser_state_t` {HUNT, DATA, CHECK};
  - the default `SYNC_WORD`, `WIDTH` and `NWORDS` constants.
- One natural sub-module, `sipo_shift`: a `WIDTH`-bit serial-in/parallel-out register with a synchronous clear. It is used for both the hunt window and the word register.
- The FSM, counters and output registers live in the top module.

## Test plan
- Reset held for 5 cycles while `din` toggles → `data_out`=0, `data_valid`=0, `locked`=0, `sync_err`=0 every cycle.
- Normal frame, defaults:
  - stimulus: bits of A5, then 3C, C3, then A5, then 11, 22;
  - `locked` rises at the 8th sync bit edge;
  - `data_valid` with `data_out`=3C at +8 cycles and C3 at +16;
  - `locked` stays high through the second sync word;
  - then 11 and 22 arrive; `sync_err` never fires.
- Bad resync:
  - stimulus: A5, 3C, C3, then FF;
  - `sync_err` pulses one cycle at the 8th FF bit edge and `locked` falls there;
  - a following A5 relocks.
- Offset hunt:
  - stimulus: noise 1,0,1 after reset, then A5, 7E, 81;
  - lock occurs exactly at the last A5 bit;
  - words 7E and 81 are reported with no bit slip.
- Guard, with `SYNC_WORD`=8'h05:
  - send 1,0,1 immediately after reset → no lock, because the window zero-fill must not match;
  - later, 8 full bits 00000101 → lock.
- Reset mid-word:
  - after lock, assert `reset` at data bit 4 of a word;
  - at that edge all outputs return to 0;
  - that word produces no `data_valid`, and the block hunts afresh.
